escalonador_buscas: RTL and testbench

//  Front-end scheduler for the shortest-path core (top). Accepts search requests (fonte, destino) from
//  NUM_REQ requesters via round-robin arbitration and launches one search at a time. Streams the

---
 rtl/dsc_pkg.sv | 20 ++
 rtl/arbitro_rr.sv | 34 +++
 rtl/escalonador_buscas.sv | 178 +++++++++++++++++
 tb/tb_escalonador_buscas.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsc_pkg.sv
// rtl/dsc_pkg.sv - shared state type, default sizes and id-width helper for the search scheduler
package dsc_pkg;
    localparam int NUM_REQ_DEF    = 4;
    localparam int ADDR_WIDTH_DEF = 8;
    localparam int TIMEOUT_DEF    = 500000;
    localparam int OBST_BURST_DEF = 8;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ID_W = id_width(NUM_REQ_DEF);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        BUSCA  = 2'd2,
        ABORT  = 2'd3
    } estado_esc_t;
endpackage

// File: rtl/arbitro_rr.sv
// rtl/arbitro_rr.sv - rotating-priority arbiter: one-hot grant plus encoded index
module arbitro_rr
    import dsc_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int IDW     = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDW-1:0]     idx_o,
    output logic               any_o
);
    logic [IDW-1:0] cand;
    logic           found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        // walk upwards from the pointer, wrapping, and keep the first requester seen
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDW'((int'(ptr_i) + k) % NUM_REQ);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

    assign any_o = |req_i;
endmodule

// File: rtl/escalonador_buscas.sv
// rtl/escalonador_buscas.sv - round-robin search scheduler and obstacle-write serialiser for the path core
module escalonador_buscas
    import dsc_pkg::*;
#(
    parameter int NUM_REQ     = NUM_REQ_DEF,
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_DEF,
    parameter int OBST_BURST  = OBST_BURST_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid_in,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_fonte_in,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_destino_in,
    output logic [NUM_REQ-1:0]            req_ready_out,
    input  logic                          obs_valid_in,
    input  logic [ADDR_WIDTH-1:0]         obs_addr_in,
    input  logic                          obs_data_in,
    output logic                          obs_ready_out,
    output logic [ADDR_WIDTH-1:0]         core_addr_fonte_out,
    output logic [ADDR_WIDTH-1:0]         core_addr_destino_out,
    output logic                          core_wr_fonte_out,
    output logic                          core_obst_wr_en_out,
    output logic [ADDR_WIDTH-1:0]         core_obst_wr_addr_out,
    output logic                          core_obst_wr_data_out,
    input  logic                          core_cam_valid_in,
    input  logic [ADDR_WIDTH-1:0]         core_cam_addr_in,
    input  logic                          core_pronto_in,
    output logic                          core_abort_out,
    output logic                          resp_valid_out,
    output logic [ADDR_WIDTH-1:0]         resp_addr_out,
    output logic [$clog2(NUM_REQ)-1:0]    resp_id_out,
    output logic                          resp_last_out,
    output logic                          resp_timeout_out,
    output logic                          busy_out
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int BW  = $clog2(OBST_BURST + 1);
    localparam int TW  = $clog2(TIMEOUT_CYC + 1);

    estado_esc_t           state_q;
    logic [IDW-1:0]        rr_q, rr_d, id_q, gnt_idx;
    logic [NUM_REQ-1:0]    gnt;
    logic                  any_req, obs_take, req_take, in_idle;
    logic [BW-1:0]         burst_q, burst_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [ADDR_WIDTH-1:0] fonte_arr   [NUM_REQ];
    logic [ADDR_WIDTH-1:0] destino_arr [NUM_REQ];

    logic                  core_wr_fonte_q, core_abort_q;
    logic [ADDR_WIDTH-1:0] core_fonte_q, core_destino_q;
    logic                  obst_en_q, obst_data_q;
    logic [ADDR_WIDTH-1:0] obst_addr_q;
    logic                  resp_valid_q, resp_last_q, resp_timeout_q;
    logic [ADDR_WIDTH-1:0] resp_addr_q;
    logic [IDW-1:0]        resp_id_q;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign fonte_arr[g]   = req_fonte_in[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign destino_arr[g] = req_destino_in[g*ADDR_WIDTH +: ADDR_WIDTH];
    end

    arbitro_rr #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_arbitro (
        .req_i   (req_valid_in),
        .ptr_i   (rr_q),
        .gnt_o   (gnt),
        .idx_o   (gnt_idx),
        .any_o   (any_req)
    );

    // Obstacle writes win in IDLE until a waiting search has seen OBST_BURST of them.
    assign in_idle  = (state_q == IDLE) && !rst_n;
    assign obs_take = in_idle && obs_valid_in && (!any_req || (burst_q < BW'(OBST_BURST)));
    assign req_take = in_idle && any_req && !obs_take;

    assign obs_ready_out = obs_take;
    assign req_ready_out = req_take ? gnt : '0;
    assign busy_out      = (state_q != IDLE);

    assign rr_d    = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    assign burst_d = !any_req ? '0 : (obs_take ? burst_q + 1'b1 : burst_q);
    assign timer_d = (timer_q == TW'(TIMEOUT_CYC)) ? timer_q : timer_q + 1'b1;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q         <= IDLE;
            rr_q            <= '0;
            id_q            <= '0;
            burst_q         <= '0;
            timer_q         <= '0;
            core_wr_fonte_q <= 1'b0;
            core_fonte_q    <= '0;
            core_destino_q  <= '0;
            core_abort_q    <= 1'b0;
            obst_en_q       <= 1'b0;
            obst_addr_q     <= '0;
            obst_data_q     <= 1'b0;
            resp_valid_q    <= 1'b0;
            resp_last_q     <= 1'b0;
            resp_timeout_q  <= 1'b0;
            resp_addr_q     <= '0;
            resp_id_q       <= '0;
        end else begin
            core_wr_fonte_q <= 1'b0;
            core_fonte_q    <= '0;
            core_destino_q  <= '0;
            core_abort_q    <= 1'b0;
            resp_valid_q    <= 1'b0;
            resp_last_q     <= 1'b0;
            resp_timeout_q  <= 1'b0;
            resp_addr_q     <= '0;
            resp_id_q       <= '0;
            obst_en_q       <= obs_take;
            obst_addr_q     <= obs_take ? obs_addr_in : '0;
            obst_data_q     <= obs_take & obs_data_in;
            burst_q         <= burst_d;

            case (state_q)
                IDLE: begin
                    if (req_take) begin
                        core_wr_fonte_q <= 1'b1;
                        core_fonte_q    <= fonte_arr[gnt_idx];
                        core_destino_q  <= destino_arr[gnt_idx];
                        id_q            <= gnt_idx;
                        rr_q            <= rr_d;
                        burst_q         <= '0;
                        state_q         <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    timer_q <= '0;
                    state_q <= BUSCA;
                end
                BUSCA: begin
                    timer_q <= timer_d;
                    if (core_cam_valid_in || core_pronto_in) begin
                        resp_valid_q <= 1'b1;
                        resp_addr_q  <= core_cam_valid_in ? core_cam_addr_in : '0;
                        resp_id_q    <= id_q;
                    end
                    // completion on the last timer cycle still counts as a normal finish
                    if (core_pronto_in) begin
                        resp_last_q <= 1'b1;
                        state_q     <= IDLE;
                    end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
                        core_abort_q   <= 1'b1;
                        resp_valid_q   <= 1'b1;
                        resp_last_q    <= 1'b1;
                        resp_timeout_q <= 1'b1;
                        resp_addr_q    <= '0;
                        resp_id_q      <= id_q;
                        state_q        <= ABORT;
                    end
                end
                ABORT: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign core_wr_fonte_out     = core_wr_fonte_q;
    assign core_addr_fonte_out   = core_fonte_q;
    assign core_addr_destino_out = core_destino_q;
    assign core_abort_out        = core_abort_q;
    assign core_obst_wr_en_out   = obst_en_q;
    assign core_obst_wr_addr_out = obst_addr_q;
    assign core_obst_wr_data_out = obst_data_q;
    assign resp_valid_out        = resp_valid_q;
    assign resp_last_out         = resp_last_q;
    assign resp_timeout_out      = resp_timeout_q;
    assign resp_addr_out         = resp_addr_q;
    assign resp_id_out           = resp_id_q;
endmodule

// File: tb/tb_escalonador_buscas.sv
// tb/tb_escalonador_buscas.sv - directed self-checking bench for escalonador_buscas
module tb_escalonador_buscas;
    import dsc_pkg::*;

    localparam int NR = 4;
    localparam int AW = 8;
    localparam int TO = 100;
    localparam int OB = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [NR-1:0]     req_valid_in = '0;
    logic [NR*AW-1:0]  req_fonte_in = '0;
    logic [NR*AW-1:0]  req_destino_in = '0;
    logic [NR-1:0]     req_ready_out;
    logic              obs_valid_in = 1'b0;
    logic [AW-1:0]     obs_addr_in = '0;
    logic              obs_data_in = 1'b0;
    logic              obs_ready_out;
    logic [AW-1:0]     core_addr_fonte_out, core_addr_destino_out;
    logic              core_wr_fonte_out, core_obst_wr_en_out, core_obst_wr_data_out;
    logic [AW-1:0]     core_obst_wr_addr_out;
    logic              core_cam_valid_in = 1'b0;
    logic [AW-1:0]     core_cam_addr_in = '0;
    logic              core_pronto_in = 1'b0;
    logic              core_abort_out, resp_valid_out, resp_last_out, resp_timeout_out, busy_out;
    logic [AW-1:0]     resp_addr_out;
    logic [ID_W-1:0]   resp_id_out;

    int applied = 0;
    int miscompares = 0;
    int n_launch = 0, n_obst = 0, n_overlap = 0, n_abort = 0;
    int n;

    escalonador_buscas #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .TIMEOUT_CYC(TO), .OBST_BURST(OB)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_in(req_valid_in), .req_fonte_in(req_fonte_in),
        .req_destino_in(req_destino_in), .req_ready_out(req_ready_out),
        .obs_valid_in(obs_valid_in), .obs_addr_in(obs_addr_in),
        .obs_data_in(obs_data_in), .obs_ready_out(obs_ready_out),
        .core_addr_fonte_out(core_addr_fonte_out), .core_addr_destino_out(core_addr_destino_out),
        .core_wr_fonte_out(core_wr_fonte_out), .core_obst_wr_en_out(core_obst_wr_en_out),
        .core_obst_wr_addr_out(core_obst_wr_addr_out), .core_obst_wr_data_out(core_obst_wr_data_out),
        .core_cam_valid_in(core_cam_valid_in), .core_cam_addr_in(core_cam_addr_in),
        .core_pronto_in(core_pronto_in), .core_abort_out(core_abort_out),
        .resp_valid_out(resp_valid_out), .resp_addr_out(resp_addr_out),
        .resp_id_out(resp_id_out), .resp_last_out(resp_last_out),
        .resp_timeout_out(resp_timeout_out), .busy_out(busy_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (core_wr_fonte_out) n_launch++;
        if (core_obst_wr_en_out) n_obst++;
        if (core_obst_wr_en_out && busy_out) n_overlap++;
        if (core_abort_out) n_abort++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        applied++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        chk("rst_busy", busy_out, 0);
        chk("rst_resp_valid", resp_valid_out, 0);
        chk("rst_wr_fonte", core_wr_fonte_out, 0);
        chk("rst_abort", core_abort_out, 0);
        chk("rst_obst_en", core_obst_wr_en_out, 0);
        rst_n = 1'b0;
        tick();

        // all requesters held: grants rotate 0,1,2,3,0
        for (int i = 0; i < NR; i++) begin
            req_fonte_in[i*AW +: AW]   = 8'(16 + i);
            req_destino_in[i*AW +: AW] = 8'(32 + i);
        end
        req_valid_in = 4'hF;
        for (int k = 0; k < 5; k++) begin
            int g;
            g = k % NR;
            @(negedge clk);
            chk("rr_grant", req_ready_out, 32'(1) << g);
            tick();
            chk("rr_launch", core_wr_fonte_out, 1);
            chk("rr_fonte", core_addr_fonte_out, 16 + g);
            chk("rr_destino", core_addr_destino_out, 32 + g);
            tick();
            core_cam_valid_in = 1'b1;
            core_cam_addr_in  = 8'(48 + g);
            core_pronto_in    = 1'b1;
            tick();
            core_cam_valid_in = 1'b0;
            core_pronto_in    = 1'b0;
            if (k == 4) req_valid_in = '0;
            chk("rr_resp_valid", resp_valid_out, 1);
            chk("rr_resp_id", resp_id_out, g);
            chk("rr_resp_addr", resp_addr_out, 48 + g);
            chk("rr_resp_last", resp_last_out, 1);
        end

        // single request from 2, path 5 -> 13 -> 40
        req_fonte_in = '0;
        req_destino_in = '0;
        req_fonte_in[2*AW +: AW]   = 8'd5;
        req_destino_in[2*AW +: AW] = 8'd40;
        req_fonte_in[1*AW +: AW]   = 8'hEE;
        req_valid_in = 4'b0100;
        @(negedge clk);
        chk("t1_ready", req_ready_out, 4'b0100);
        tick();
        req_valid_in = '0;
        req_fonte_in = '1;
        chk("t1_wr_fonte", core_wr_fonte_out, 1);
        chk("t1_fonte", core_addr_fonte_out, 5);
        chk("t1_destino", core_addr_destino_out, 40);
        chk("t1_busy", busy_out, 1);
        tick();
        chk("t1_wr_fonte_end", core_wr_fonte_out, 0);
        chk("t1_fonte_zero", core_addr_fonte_out, 0);
        core_cam_valid_in = 1'b1;
        core_cam_addr_in  = 8'd5;
        tick();
        chk("t1_b0_valid", resp_valid_out, 1);
        chk("t1_b0_addr", resp_addr_out, 5);
        chk("t1_b0_id", resp_id_out, 2);
        chk("t1_b0_last", resp_last_out, 0);
        core_cam_addr_in = 8'd13;
        tick();
        chk("t1_b1_addr", resp_addr_out, 13);
        chk("t1_b1_last", resp_last_out, 0);
        core_cam_addr_in = 8'd40;
        core_pronto_in   = 1'b1;
        tick();
        core_cam_valid_in = 1'b0;
        core_pronto_in    = 1'b0;
        chk("t1_b2_valid", resp_valid_out, 1);
        chk("t1_b2_addr", resp_addr_out, 40);
        chk("t1_b2_last", resp_last_out, 1);
        chk("t1_b2_id", resp_id_out, 2);
        chk("t1_idle", busy_out, 0);
        tick();
        chk("t1_single_final", resp_valid_out, 0);
        chk("t1_launches", n_launch, 6);
        core_cam_valid_in = 1'b1;
        core_cam_addr_in  = 8'h77;
        tick();
        core_cam_valid_in = 1'b0;
        chk("idle_strobe_ignored", resp_valid_out, 0);

        // 20 obstacle writes racing a waiting request from 1
        req_fonte_in[1*AW +: AW]   = 8'd7;
        req_destino_in[1*AW +: AW] = 8'd9;
        req_valid_in = 4'b0010;
        obs_valid_in = 1'b1;
        obs_addr_in  = 8'd0;
        obs_data_in  = 1'b0;
        for (int c = 0; c < OB; c++) begin
            @(negedge clk);
            chk("t3_obs_ready", obs_ready_out, 1);
            chk("t3_req_wait", req_ready_out, 0);
            tick();
            chk("t3_obst_en", core_obst_wr_en_out, 1);
            chk("t3_obst_addr", core_obst_wr_addr_out, c);
            chk("t3_obst_data", core_obst_wr_data_out, c & 1);
            obs_addr_in = 8'(c + 1);
            obs_data_in = 1'((c + 1) & 1);
        end
        @(negedge clk);
        chk("t3_burst_limit", obs_ready_out, 0);
        chk("t3_req_grant", req_ready_out, 4'b0010);
        tick();
        req_valid_in = '0;
        chk("t3_launch_fonte", core_addr_fonte_out, 7);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("t3_obs_blocked", obs_ready_out, 0);
            tick();
        end
        core_pronto_in = 1'b1;
        tick();
        core_pronto_in = 1'b0;
        chk("t3_last", resp_last_out, 1);
        chk("t3_last_addr", resp_addr_out, 0);
        chk("t3_last_id", resp_id_out, 1);
        for (int c = OB; c < 20; c++) begin
            @(negedge clk);
            chk("t3_obs_resume", obs_ready_out, 1);
            tick();
            chk("t3_resume_addr", core_obst_wr_addr_out, c);
            obs_addr_in = 8'(c + 1);
            obs_data_in = 1'((c + 1) & 1);
            if (c == 19) obs_valid_in = 1'b0;
        end
        tick();
        chk("t3_obst_total", n_obst, 20);
        chk("t3_no_overlap", n_overlap, 0);

        // timeout: core never finishes
        req_fonte_in[0*AW +: AW]   = 8'd3;
        req_destino_in[0*AW +: AW] = 8'd4;
        req_valid_in = 4'b0001;
        @(negedge clk);
        chk("t4_ready", req_ready_out, 4'b0001);
        tick();
        req_valid_in = '0;
        chk("t4_launch", core_wr_fonte_out, 1);
        n = 0;
        do begin
            tick();
            n++;
        end while (!core_abort_out && n < 200);
        chk("t4_abort_latency", n, TO + 1);
        chk("t4_timeout", resp_timeout_out, 1);
        chk("t4_last", resp_last_out, 1);
        chk("t4_valid", resp_valid_out, 1);
        chk("t4_id", resp_id_out, 0);
        tick();
        chk("t4_abort_pulse", core_abort_out, 0);
        chk("t4_idle", busy_out, 0);

        // pronto on the final timer cycle beats the timeout
        req_valid_in = 4'b0010;
        @(negedge clk);
        chk("t5_ready", req_ready_out, 4'b0010);
        tick();
        req_valid_in = '0;
        repeat (TO) tick();
        core_pronto_in = 1'b1;
        tick();
        core_pronto_in = 1'b0;
        chk("t5_no_abort", core_abort_out, 0);
        chk("t5_no_timeout", resp_timeout_out, 0);
        chk("t5_last", resp_last_out, 1);
        chk("t5_id", resp_id_out, 1);
        chk("t5_abort_count", n_abort, 1);

        // reset in the middle of a search
        req_valid_in = 4'b0100;
        @(negedge clk);
        chk("t6_ready", req_ready_out, 4'b0100);
        tick();
        req_valid_in = '0;
        tick();
        core_cam_valid_in = 1'b1;
        core_cam_addr_in  = 8'h55;
        #2 rst_n = 1'b1;
        #1;
        chk("t6_busy", busy_out, 0);
        chk("t6_resp_valid", resp_valid_out, 0);
        chk("t6_abort", core_abort_out, 0);
        tick();
        core_cam_valid_in = 1'b0;
        chk("t6_no_resp", resp_valid_out, 0);
        rst_n = 1'b0;
        req_valid_in = 4'hF;
        @(negedge clk);
        chk("t6_rr_reset", req_ready_out, 4'b0001);
        tick();
        req_valid_in = '0;
        chk("t6_fonte", core_addr_fonte_out, 3);
        tick();
        core_pronto_in = 1'b1;
        tick();
        core_pronto_in = 1'b0;
        chk("t6_id", resp_id_out, 0);
        chk("t6_last", resp_last_out, 1);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
